program_loader: RTL and testbench

- Writer side of the CPU's instruction/data memory: loads a program image from a byte stream into the 8-bit memory before the multicycle CPU fetches from it.
- Holds the CPU in reset while loading, verifies a checksum, then releases the CPU.
- Sits between a host byte source (UART receiver or testbench) and the memory write port, in front of the CPU's fetch path.

---
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program image loader: parses SYNC/LEN/data/CHK frames from a byte stream,
// writes the data bytes into CPU memory and releases the CPU once verified.
module program_loader #(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   // Debug view of the FSM: 0 WAIT_SYNC, 1 GET_LEN, 2 GET_DATA, 3 GET_CHK, 4 RUN, 5 ERROR
   output logic [2:0]        dbg_state
);

   // Stream handshake: a byte moves only on a rising edge with in_valid && in_ready.
   // in_valid may rise or fall on any cycle; in_ready is a pure function of state
   // and never depends on in_valid, so the source can wait on it safely.

   typedef enum logic [2:0] {
      WAIT_SYNC = 3'd0,
      GET_LEN   = 3'd1,
      GET_DATA  = 3'd2,
      GET_CHK   = 3'd3,
      RUN       = 3'd4,
      ERROR     = 3'd5
   } state_t;

   state_t            state;
   logic [7:0]        count;
   logic [7:0]        sum;
   logic [ADDR_W-1:0] ptr;
   logic              accept;
   logic              len_bad;

   assign in_ready  = (state != RUN) && (state != ERROR);
   assign accept    = in_valid && in_ready;
   assign dbg_state = state;

   // A length must be non-zero and must fit below the top of the address space.
   generate
      if (ADDR_W >= 8) begin : g_len_full
         assign len_bad = (in_data == 8'd0);
      end else begin : g_len_narrow
         assign len_bad = (in_data == 8'd0) || (in_data[7:ADDR_W] != '0);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= WAIT_SYNC;
         count     <= 8'd0;
         sum       <= 8'd0;
         ptr       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            WAIT_SYNC: begin
               if (accept && (in_data == SYNC_BYTE)) begin
                  state <= GET_LEN;
               end
            end
            GET_LEN: begin
               if (accept) begin
                  count <= in_data;
                  sum   <= 8'd0;
                  ptr   <= '0;
                  if (len_bad) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else begin
                     state <= GET_DATA;
                  end
               end
            end
            GET_DATA: begin
               // Write is issued one cycle after acceptance from the registered copy.
               if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= ptr;
                  mem_wdata <= in_data;
                  ptr       <= ptr + ADDR_W'(1);
                  count     <= count - 8'd1;
                  sum       <= sum + in_data;
                  if (count == 8'd1) begin
                     state <= GET_CHK;
                  end
               end
            end
            GET_CHK: begin
               if (accept) begin
                  if (in_data == sum) begin
                     state     <= RUN;
                     cpu_reset <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end
            RUN, ERROR: begin
               // Re-arm keeps memory contents; only the status is cleared.
               if (start) begin
                  state     <= WAIT_SYNC;
                  cpu_reset <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
               end
            end
            default: begin
               state     <= WAIT_SYNC;
               cpu_reset <= 1'b1;
               done      <= 1'b0;
               error     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames, a frame-level model that predicts
// memory writes and outcome, and a per-cycle compare process on the write port.
module tb_program_loader;

   typedef logic [7:0] bytes_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       start = 1'b0;
   logic       in_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_reset;
   logic       done;
   logic       error;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   logic [15:0] exp_q[$];
   int          wr_cyc[$];

   program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      cycle++;
      if (reset) begin
         check("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~done});
         if (mem_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", {16'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
               check("mem_write", {16'd0, mem_addr, mem_wdata}, {16'd0, exp_q.pop_front()});
               wr_cyc.push_back(cycle);
            end
         end
      end
   end

   // ---------------- model ----------------
   // Frame-level view: find the sync marker, read LEN, queue LEN writes at
   // addresses 0.., then compare the trailing byte with the byte-sum.
   task automatic predict(input bytes_t b, output int used, output bit ok_run,
                          output logic [7:0] msum, output int nwr);
      int i = 0;
      int len;
      int s = 0;
      used = b.size(); ok_run = 1'b0; msum = 8'd0; nwr = 0;
      while (i < b.size() && b[i] != 8'hA5) i++;
      if (i + 1 >= b.size()) return;
      len = int'(b[i+1]);
      if (len == 0) begin
         used = i + 2;
         return;
      end
      for (int k = 0; k < len; k++) begin
         exp_q.push_back({k[7:0], b[i+2+k]});
         s = s + int'(b[i+2+k]);
      end
      msum   = s[7:0];
      nwr    = len;
      ok_run = (b[i+2+len] == s[7:0]);
      used   = i + 3 + len;
   endtask

   // ---------------- drivers ----------------
   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      bit acc;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int n = 0; n < 50; n++) begin
         acc = in_ready;
         @(posedge clk);
         @(negedge clk);
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input string name, input bytes_t b, input int gap,
                            output logic [7:0] msum, output int nwr, output bit ok_run);
      int used;
      bit ok;
      predict(b, used, ok_run, msum, nwr);
      for (int i = 0; i < used; i++) begin
         if (i > 0) repeat (gap) @(negedge clk);
         send_byte(b[i], ok);
         check({name, "_accept"}, {31'd0, ok}, 32'd1);
      end
      check({name, "_done"},      {31'd0, done},      {31'd0, ok_run});
      check({name, "_error"},     {31'd0, error},     {31'd0, ~ok_run});
      check({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~ok_run});
      check({name, "_in_ready"},  {31'd0, in_ready},  32'd0);
      check({name, "_writes_left"}, exp_q.size(), 32'd0);
   endtask

   task automatic pulse_start(input string name);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_error"},     {31'd0, error},     32'd0);
      check({name, "_done"},      {31'd0, done},      32'd0);
      check({name, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
      check({name, "_in_ready"},  {31'd0, in_ready},  32'd1);
      check({name, "_state"},     {29'd0, dbg_state}, 32'd0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_mem_we"},    {31'd0, mem_we},     32'd0);
      check({name, "_mem_addr"},  {24'd0, mem_addr},   32'd0);
      check({name, "_mem_wdata"}, {24'd0, mem_wdata},  32'd0);
      check({name, "_cpu_reset"}, {31'd0, cpu_reset},  32'd1);
      check({name, "_done"},      {31'd0, done},       32'd0);
      check({name, "_error"},     {31'd0, error},      32'd0);
      check({name, "_in_ready"},  {31'd0, in_ready},   32'd1);
      check({name, "_state"},     {29'd0, dbg_state},  32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bytes_t     f;
      logic [7:0] msum;
      int         nwr;
      bit         okr;
      bit         ok;

      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b1;
      @(negedge clk);

      // 1: basic three-byte image, back-to-back writes
      wr_cyc.delete();
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
      run_frame("t1", f, 0, msum, nwr, okr);
      check("t1_model_sum",    {24'd0, msum}, 32'h66);
      check("t1_model_writes", nwr,           32'd3);
      check("t1_model_ok",     {31'd0, okr},  32'd1);
      check("t1_write_count",  wr_cyc.size(), 32'd3);
      if (wr_cyc.size() == 3) begin
         check("t1_consecutive_a", wr_cyc[1] - wr_cyc[0], 32'd1);
         check("t1_consecutive_b", wr_cyc[2] - wr_cyc[1], 32'd1);
      end
      pulse_start("t1_start");

      // 2: leading junk discarded, single FF byte
      f = '{8'h00, 8'h7F, 8'hA5, 8'h01, 8'hFF, 8'hFF};
      run_frame("t2", f, 0, msum, nwr, okr);
      check("t2_model_writes", nwr, 32'd1);
      pulse_start("t2_start");

      // 3: bad checksum, writes still happen
      f = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      run_frame("t3", f, 0, msum, nwr, okr);
      check("t3_model_sum", {24'd0, msum}, 32'h30);
      check("t3_model_ok",  {31'd0, okr},  32'd0);
      pulse_start("t3_start");

      // 4: zero length, stream stalled afterwards
      f = '{8'hA5, 8'h00};
      run_frame("t4", f, 0, msum, nwr, okr);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_stalled_ready", {31'd0, in_ready}, 32'd0);
         check("t4_stalled_error", {31'd0, error},    32'd1);
      end
      in_valid = 1'b0;
      check("t4_state", {29'd0, dbg_state}, 32'd5);
      pulse_start("t4_start");

      // 5: in_valid gaps between bytes
      f = '{8'hA5, 8'h04, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hC0};
      run_frame("t5", f, 1, msum, nwr, okr);
      check("t5_model_sum", {24'd0, msum}, 32'hC0);
      pulse_start("t5_start");

      // 6: asynchronous reset mid-frame while a write is on the port
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0102);
      f = '{8'hA5, 8'h04, 8'h01, 8'h02};
      for (int i = 0; i < 4; i++) begin
         send_byte(f[i], ok);
         check("t6_accept", {31'd0, ok}, 32'd1);
      end
      check("t6_we_before_reset", {31'd0, mem_we}, 32'd1);
      #2 reset = 1'b0;
      #1 check_reset_values("t6_async");
      check("t6_writes_left", exp_q.size(), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
      run_frame("t6_reload", f, 0, msum, nwr, okr);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
